// File: rtl/sub16_nibble_sequencer.sv
// Nibble-serial unsigned subtractor: z = {borrow, x - y}.
// A single 4-bit ripple-borrow slice is reused once per nibble, least
// significant nibble first, with the borrow carried between steps in a
// register. Handshake: operands enter in IDLE, the result is offered in DONE.
module sub16_nibble_sequencer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   z,
    output logic             busy
);

    localparam int NIB = WIDTH / 4;
    localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(NIB - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_r;
    logic [CW-1:0]    cnt_r;
    logic             borrow_r;
    logic [WIDTH-1:0] x_r;
    logic [WIDTH-1:0] y_r;
    logic [WIDTH:0]   z_r;

    logic [3:0]       a_nib_s;
    logic [3:0]       b_nib_s;
    logic [4:0]       slice_s;
    logic [3:0]       diff_s;
    logic             bout_s;

    // Four full-subtractor cells chained LSB to MSB; returns {Bout, D[3:0]}.
    function automatic logic [4:0] sub_slice(
        input logic [3:0] a,
        input logic [3:0] b,
        input logic       bin
    );
        logic [3:0] d;
        logic       br;
        d  = 4'b0000;
        br = bin;
        for (int i = 0; i < 4; i++) begin
            d[i] = a[i] ^ b[i] ^ br;
            br   = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & br);
        end
        return {br, d};
    endfunction

    // Select the current nibble of the captured operands and run the shared slice.
    always_comb begin
        a_nib_s = x_r[{cnt_r, 2'b00} +: 4];
        b_nib_s = y_r[{cnt_r, 2'b00} +: 4];
        slice_s = sub_slice(a_nib_s, b_nib_s, borrow_r);
        diff_s  = slice_s[3:0];
        bout_s  = slice_s[4];
    end

    // Sequencer: capture in IDLE, one nibble per RUN cycle, hold result in DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= IDLE;
            cnt_r    <= '0;
            borrow_r <= 1'b0;
            x_r      <= '0;
            y_r      <= '0;
            z_r      <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        x_r      <= x;
                        y_r      <= y;
                        borrow_r <= 1'b0;
                        cnt_r    <= '0;
                        state_r  <= RUN;
                    end else begin
                        state_r  <= IDLE;
                    end
                end
                RUN: begin
                    z_r[{cnt_r, 2'b00} +: 4] <= diff_s;
                    borrow_r                 <= bout_s;
                    if (cnt_r == LAST_CNT) begin
                        z_r[WIDTH] <= bout_s;
                        cnt_r      <= '0;
                        state_r    <= DONE;
                    end else begin
                        cnt_r      <= cnt_r + CW'(1);
                        state_r    <= RUN;
                    end
                end
                DONE: begin
                    // Result stays put under backpressure; no direct path back to RUN.
                    if (out_ready) begin
                        state_r <= IDLE;
                    end else begin
                        state_r <= DONE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    // Handshake and status flags decode straight from the state register.
    always_comb begin
        in_ready  = (state_r == IDLE);
        out_valid = (state_r == DONE);
        busy      = (state_r != IDLE);
        z         = z_r;
    end

endmodule
